// File: rtl/i2c_regs_pkg.sv
// Shared register map, CONFIG/STATUS bit positions and MODE layout for the
// I2C master CPU register file.
package i2c_regs_pkg;

    localparam logic [2:0] ADDR_CONFIG   = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_SADDR_LO = 3'd2;
    localparam logic [2:0] ADDR_SADDR_HI = 3'd3;
    localparam logic [2:0] ADDR_BYTE_CNT = 3'd4;
    localparam logic [2:0] ADDR_TX_DATA  = 3'd5;
    localparam logic [2:0] ADDR_RX_DATA  = 3'd6;
    localparam logic [2:0] ADDR_STATUS   = 3'd7;

    localparam int CFG_START    = 0;
    localparam int CFG_INT_CLR  = 1;
    localparam int CFG_RX_IE    = 2;
    localparam int CFG_TX_IE    = 3;
    localparam int CFG_ABORT    = 4;
    localparam int CFG_SOFT_RST = 5;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UDF   = 5;
    localparam int ST_BUSY     = 6;
    localparam int ST_DONE     = 7;

    typedef struct packed {
        logic [1:0] bps;
        logic       adr_mod;
        logic       rsvd4;
        logic       rw_mod;
        logic [2:0] rsvd_lo;
    } mode_t;

    // Reserved MODE bits always read back as zero.
    function automatic mode_t mode_sanitize(input logic [7:0] raw);
        mode_t m;
        m         = mode_t'(raw);
        m.rsvd4   = 1'b0;
        m.rsvd_lo = 3'b000;
        return m;
    endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module i2c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; validity is tracked by count, and dout is gated while empty.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2c_cpu_regfile.sv
// CPU-side register file for the I2C master: config/mode/address registers,
// TX/RX FIFOs, sticky status flags, one-cycle command pulses and interrupt.
module i2c_cpu_regfile
    import i2c_regs_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int SADDR_W  = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [2:0]         addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               rd_valid,
    output logic               start_pulse,
    output logic               abort_pulse,
    output logic [DATA_W-1:0]  mode,
    output logic [SADDR_W-1:0] slave_addr,
    output logic [DATA_W-1:0]  byte_cnt,
    input  logic               tx_pop,
    output logic [DATA_W-1:0]  tx_dout,
    output logic               tx_empty,
    input  logic               rx_push,
    input  logic [DATA_W-1:0]  rx_din,
    output logic               rx_full,
    input  logic               core_done,
    input  logic               core_busy,
    output logic               irq
);

    localparam int HI_W = SADDR_W - 8;

    mode_t            mode_q;
    logic [7:0]       saddr_lo;
    logic [HI_W-1:0]  saddr_hi;
    logic             rx_ie;
    logic             tx_ie;
    logic             tx_ovf;
    logic             rx_udf;
    logic             done_flag;

    logic             wr_cfg;
    logic             soft_rst;
    logic             flag_clr;
    logic             tx_push;
    logic             tx_full;
    logic             rx_rd;
    logic             rx_pop;
    logic             rx_empty;
    logic             tx_ovf_set;
    logic             rx_udf_set;
    logic [DATA_W-1:0] rx_dout;
    logic [7:0]        status;
    logic [DATA_W-1:0] rd_mux;

    assign wr_cfg     = wr_en && (addr == ADDR_CONFIG);
    assign soft_rst   = wr_cfg && wdata[CFG_SOFT_RST];
    assign flag_clr   = soft_rst || (wr_cfg && wdata[CFG_INT_CLR]);
    assign tx_push    = wr_en && (addr == ADDR_TX_DATA);
    assign rx_rd      = rd_en && (addr == ADDR_RX_DATA);
    assign rx_pop     = rx_rd && !rx_empty;
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_udf_set = rx_rd && rx_empty && !rx_push;

    assign mode       = DATA_W'(mode_q);
    assign slave_addr = {saddr_hi, saddr_lo};

    i2c_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (soft_rst),
        .din   (wdata),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    i2c_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (soft_rst),
        .din   (rx_din),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // NOTE: sequential state uses non-blocking assignments only; combinational blocks default every output first.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_q      <= '0;
            saddr_lo    <= '0;
            saddr_hi    <= '0;
            byte_cnt    <= '0;
            rx_ie       <= 1'b0;
            tx_ie       <= 1'b0;
            start_pulse <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            start_pulse <= wr_cfg && wdata[CFG_START];
            abort_pulse <= wr_cfg && wdata[CFG_ABORT];
            if (wr_cfg) begin
                rx_ie <= wdata[CFG_RX_IE];
                tx_ie <= wdata[CFG_TX_IE];
            end
            if (wr_en) begin
                case (addr)
                    ADDR_MODE:     mode_q   <= mode_sanitize(wdata[7:0]);
                    ADDR_SADDR_LO: saddr_lo <= wdata[7:0];
                    ADDR_SADDR_HI: saddr_hi <= wdata[HI_W-1:0];
                    ADDR_BYTE_CNT: byte_cnt <= wdata;
                    default:       ;
                endcase
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_ovf    <= 1'b0;
            rx_udf    <= 1'b0;
            done_flag <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (tx_ovf_set)     tx_ovf <= 1'b1;
            else if (flag_clr)  tx_ovf <= 1'b0;
            if (rx_udf_set)     rx_udf <= 1'b1;
            else if (flag_clr)  rx_udf <= 1'b0;
            if (core_done)      done_flag <= 1'b1;
            else if (flag_clr)  done_flag <= 1'b0;
            irq <= (rx_ie & ~rx_empty) | (tx_ie & done_flag) | tx_ovf | rx_udf;
        end
    end

    always_comb begin
        status              = '0;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_UDF]   = rx_udf;
        status[ST_BUSY]     = core_busy;
        status[ST_DONE]     = done_flag;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CONFIG: begin
                rd_mux[CFG_RX_IE] = rx_ie;
                rd_mux[CFG_TX_IE] = tx_ie;
            end
            ADDR_MODE:     rd_mux = mode;
            ADDR_SADDR_LO: rd_mux = DATA_W'(saddr_lo);
            ADDR_SADDR_HI: rd_mux = DATA_W'(saddr_hi);
            ADDR_BYTE_CNT: rd_mux = byte_cnt;
            ADDR_RX_DATA:  rd_mux = rx_dout;
            ADDR_STATUS:   rd_mux = DATA_W'(status);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_i2c_cpu_regfile.sv
// Directed self-checking bench for i2c_cpu_regfile with hand-computed expectations.
module tb_i2c_cpu_regfile;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wr_en, rd_en;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rd_valid, start_pulse, abort_pulse;
    logic [7:0]  mode;
    logic [9:0]  slave_addr;
    logic [7:0]  byte_cnt;
    logic        tx_pop;
    logic [7:0]  tx_dout;
    logic        tx_empty;
    logic        rx_push;
    logic [7:0]  rx_din;
    logic        rx_full;
    logic        core_done, core_busy;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    i2c_cpu_regfile #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .SADDR_W(10)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rd_valid    (rd_valid),
        .start_pulse (start_pulse),
        .abort_pulse (abort_pulse),
        .mode        (mode),
        .slave_addr  (slave_addr),
        .byte_cnt    (byte_cnt),
        .tx_pop      (tx_pop),
        .tx_dout     (tx_dout),
        .tx_empty    (tx_empty),
        .rx_push     (rx_push),
        .rx_din      (rx_din),
        .rx_full     (rx_full),
        .core_done   (core_done),
        .core_busy   (core_busy),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] expected, input string tag);
        rd_en = 1'b1;
        addr  = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check(tag, rdata, expected);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        tx_pop = 1'b0; rx_push = 1'b0; rx_din = '0; core_done = 1'b0; core_busy = 1'b0;

        // Reset state
        #23;
        check("rst_tx_empty", tx_empty, 1);
        check("rst_rx_full", rx_full, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_pulses", {start_pulse, abort_pulse}, 0);
        check("rst_regs", {mode, byte_cnt, 6'b0, slave_addr}, 0);
        tick();
        RST = 1'b1;
        tick();

        // Read every address; STATUS first since an empty RX_DATA read raises rx_udf
        rd(3'd7, 8'h05, "rd0_status");
        rd(3'd0, 8'h00, "rd0_config");
        rd(3'd1, 8'h00, "rd0_mode");
        rd(3'd2, 8'h00, "rd0_saddr_lo");
        rd(3'd3, 8'h00, "rd0_saddr_hi");
        rd(3'd4, 8'h00, "rd0_byte_cnt");
        rd(3'd5, 8'h00, "rd0_tx_data");
        rd(3'd6, 8'h00, "rd0_rx_data");
        wr(3'd0, 8'h02);
        check("udf_irq_set", irq, 1);
        tick();
        check("udf_irq_clr", irq, 0);
        rd(3'd7, 8'h05, "udf_cleared_status");

        // Address / mode registers
        wr(3'd2, 8'h2A);
        wr(3'd3, 8'h03);
        wr(3'd1, 8'hC8);
        check("slave_addr", slave_addr, 10'h32A);
        check("mode_out", mode, 8'hC8);
        tick();
        check("rd_valid_idle", rd_valid, 0);
        rd(3'd2, 8'h2A, "rb_saddr_lo");
        rd(3'd3, 8'h03, "rb_saddr_hi");
        rd(3'd1, 8'hC8, "rb_mode");
        tick();
        check("rd_valid_drop", rd_valid, 0);
        wr(3'd1, 8'hFF);
        check("mode_rsvd_masked", mode, 8'hE8);
        wr(3'd1, 8'hC8);
        wr(3'd4, 8'h07);
        check("byte_cnt_out", byte_cnt, 8'h07);
        rd(3'd4, 8'h07, "rb_byte_cnt");

        // Command pulses
        wr(3'd0, 8'h01);
        check("start_hi", {start_pulse, abort_pulse}, 2'b10);
        tick();
        check("start_lo", start_pulse, 0);
        wr(3'd0, 8'h10);
        check("abort_hi", {start_pulse, abort_pulse}, 2'b01);
        tick();
        check("abort_lo", abort_pulse, 0);
        rd(3'd0, 8'h00, "rb_config_ie");

        // TX overflow and FWFT drain
        for (int i = 0; i < 5; i++) wr(3'd5, 8'h11 + 8'(i));
        rd(3'd7, 8'h16, "tx_ovf_status");
        check("tx_ovf_irq", irq, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tx_dout_%0d", i), tx_dout, 8'h11 + 8'(i));
            tx_pop = 1'b1;
            tick();
            tx_pop = 1'b0;
        end
        check("tx_drained", tx_empty, 1);
        tx_pop = 1'b1;
        tick();
        tx_pop = 1'b0;
        check("tx_pop_empty", tx_empty, 1);
        wr(3'd0, 8'h02);
        tick();
        check("tx_ovf_cleared_irq", irq, 0);

        // RX interrupt and underflow
        wr(3'd0, 8'h04);
        rx_push = 1'b1; rx_din = 8'hA5;
        tick();
        rx_push = 1'b0;
        check("rx_irq_not_yet", irq, 0);
        tick();
        check("rx_irq_rise", irq, 1);
        rd(3'd6, 8'hA5, "rx_read_a5");
        tick();
        check("rx_irq_fall", irq, 0);
        rd(3'd6, 8'h00, "rx_read_empty");
        tick();
        check("rx_udf_irq", irq, 1);
        rd(3'd7, 8'h25, "rx_udf_status");
        wr(3'd0, 8'h02);
        tick();
        check("rx_udf_irq_clr", irq, 0);
        rd(3'd7, 8'h05, "rx_udf_cleared");

        // done_flag set wins over INT_CLR; TX_IE kept by writing 0x0A
        wr(3'd0, 8'h08);
        core_done = 1'b1; wr_en = 1'b1; addr = 3'd0; wdata = 8'h0A;
        tick();
        core_done = 1'b0; wr_en = 1'b0;
        tick();
        check("done_set_wins_irq", irq, 1);
        rd(3'd7, 8'h85, "done_status");
        core_busy = 1'b1;
        rd(3'd7, 8'hC5, "busy_status");
        core_busy = 1'b0;

        // SOFT_RST flushes both FIFOs and keeps configuration
        wr(3'd5, 8'h55);
        rx_push = 1'b1; rx_din = 8'h66;
        tick();
        rx_push = 1'b0;
        check("pre_flush_tx_dout", tx_dout, 8'h55);
        rd(3'd7, 8'h80, "pre_flush_status");
        wr(3'd0, 8'h28);
        check("flush_tx_empty", tx_empty, 1);
        rd(3'd7, 8'h05, "post_flush_status");
        check("post_flush_irq", irq, 0);
        check("kept_slave_addr", slave_addr, 10'h32A);
        check("kept_mode", mode, 8'hC8);
        rd(3'd0, 8'h08, "kept_tx_ie");

        // RX full: fifth push dropped silently
        rx_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_din = 8'h31 + 8'(i);
            tick();
        end
        rx_push = 1'b0;
        check("rx_full", rx_full, 1);
        rd(3'd7, 8'h09, "rx_full_status");
        for (int i = 0; i < 4; i++) rd(3'd6, 8'h31 + 8'(i), $sformatf("rx_drain_%0d", i));
        rd(3'd7, 8'h05, "rx_drained_status");

        // Push and pop together while TX is full: both accepted, no overflow
        for (int i = 0; i < 4; i++) wr(3'd5, 8'h41 + 8'(i));
        tx_pop = 1'b1; wr_en = 1'b1; addr = 3'd5; wdata = 8'h45;
        tick();
        tx_pop = 1'b0; wr_en = 1'b0;
        check("full_pushpop_head", tx_dout, 8'h42);
        rd(3'd7, 8'h06, "full_pushpop_status");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_pushpop_drain_%0d", i), tx_dout, 8'h42 + 8'(i));
            tx_pop = 1'b1;
            tick();
            tx_pop = 1'b0;
        end
        check("full_pushpop_empty", tx_empty, 1);

        // Asynchronous reset kills a pulse in flight
        wr(3'd0, 8'h01);
        check("inflight_start", start_pulse, 1);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_pulse", start_pulse, 0);
        check("async_rst_mode", mode, 0);
        RST = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
